uart_tx_arbiter: RTL

- Round-robin scheduler that shares the single UART serial transmitter (parallel-in/serial-out frame shifter) between NUM_REQ byte requesters.
- Captures one requester's byte and parity configuration, then pulses the transmitter's send enable.
- Tracks the transmitter's active/done flags through the frame and returns a per-requester completion pulse.
- Sits between client logic and the transmitter, in the baud_clk domain.

---
 rtl/uart_tx_arbiter.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART frame transmitter between NUM_REQ byte requesters using a
// round-robin pointer. A granted requester's byte and parity setting are
// captured into tx_data / tx_parity_type, which then stay stable until the next
// grant. The transmitter is then handed a one-cycle send enable. Its
// active/done flags are followed through the frame. A completion pulse goes
// back to the requester that owns the frame, or an error pulse is raised if the
// transmitter stalls. A short forced idle gap separates consecutive frames.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   TIMEOUT     cycles allowed for tx_active to rise after the send enable;
//               TIMEOUT+11 cycles allowed for the frame once active is high
//   GAP_CYCLES  extra idle cycles forced between frames (0..15)
//
// Ports
//   baud_clk        clock from the baud generator, rising edge
//   reset           asynchronous, active-high reset
//   req             per-requester level request, held until gnt
//   req_data        byte for requester i in bits [8i+7:8i]
//   req_parity      parity type for requester i in bits [2i+1:2i]
//   gnt             one-cycle one-hot grant (byte captured on this edge)
//   done            one-cycle one-hot frame-complete pulse
//   err             one-cycle pulse when a frame is aborted on timeout
//   busy            high from grant until the end of the inter-frame gap
//   tx_send         send enable to the transmitter
//   tx_data         data_in to the transmitter
//   tx_parity_type  parity_type to the transmitter
//   tx_active       active_flag from the transmitter
//   tx_done         done_flag from the transmitter
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 32,
  parameter int GAP_CYCLES = 1
) (
  input  logic                   baud_clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [2*NUM_REQ-1:0]   req_parity,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic                   busy,
  output logic                   tx_send,
  output logic [7:0]             tx_data,
  output logic [1:0]             tx_parity_type,
  input  logic                   tx_active,
  input  logic                   tx_done
);

  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int TIMER_W = $clog2(TIMEOUT + 12);

  // WAIT_ACT: the timer is cleared on the edge that raises tx_send, so the
  // abort lands TIMEOUT edges after tx_send goes high.
  localparam logic [TIMER_W-1:0] ACT_LIMIT  = TIMER_W'(TIMEOUT - 1);
  // WAIT_DONE: the timer is cleared one edge after tx_active rose (the edge
  // that samples it), so the abort lands TIMEOUT+11 edges after the rise.
  localparam logic [TIMER_W-1:0] DONE_LIMIT = TIMER_W'(TIMEOUT + 9);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;
  localparam logic [3:0]         GAP_LIMIT  = 4'(GAP_CYCLES);
  localparam logic [PTR_W-1:0]   LAST_IDX   = PTR_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_ACT  = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic [PTR_W-1:0]     ptr_reg, ptr_next;
  logic [PTR_W-1:0]     cur_reg, cur_next;
  logic [TIMER_W-1:0]   timer_reg, timer_next;
  logic [3:0]           gap_reg, gap_next;
  logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]   done_reg, done_next;
  logic                 err_reg, err_next;
  logic                 busy_reg, busy_next;
  logic                 send_reg, send_next;
  logic [7:0]           data_reg, data_next;
  logic [1:0]           par_reg, par_next;

  // Per-requester views of the packed buses and one-hot decodes.
  logic [7:0]           data_arr [NUM_REQ];
  logic [1:0]           par_arr  [NUM_REQ];
  logic [NUM_REQ-1:0]   win_onehot;
  logic [NUM_REQ-1:0]   cur_onehot;

  logic                 found;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     cand_idx;
  int                   cand;
  logic [TIMER_W-1:0]   timer_inc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]   = req_data[8*gi +: 8];
      assign par_arr[gi]    = req_parity[2*gi +: 2];
      assign win_onehot[gi] = (win_idx == PTR_W'(gi));
      assign cur_onehot[gi] = (cur_reg == PTR_W'(gi));
    end
  endgenerate

  // Round-robin search: first set request at or after ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(ptr_reg) + k) % NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!found && req[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  // Saturating increment so a stuck timer never wraps back into range.
  assign timer_inc = (timer_reg == TIMER_MAX) ? timer_reg : timer_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cur_next   = cur_reg;
    timer_next = timer_reg;
    gap_next   = gap_reg;
    gnt_next   = '0;
    done_next  = '0;
    err_next   = 1'b0;
    busy_next  = busy_reg;
    send_next  = 1'b0;
    data_next  = data_reg;
    par_next   = par_reg;

    unique case (state_reg)
      IDLE: begin
        if (found) begin
          gnt_next   = win_onehot;
          data_next  = data_arr[win_idx];
          par_next   = par_arr[win_idx];
          busy_next  = 1'b1;
          cur_next   = win_idx;
          ptr_next   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
          state_next = SEND;
        end
      end

      SEND: begin
        send_next  = 1'b1;
        timer_next = '0;
        state_next = WAIT_ACT;
      end

      WAIT_ACT: begin
        if (tx_active) begin
          timer_next = '0;
          state_next = WAIT_DONE;
        end else if (timer_reg >= ACT_LIMIT) begin
          err_next   = 1'b1;
          gap_next   = '0;
          state_next = GAP;
        end else begin
          timer_next = timer_inc;
        end
      end

      WAIT_DONE: begin
        // Completion is taken only once active has dropped with done high.
        if (!tx_active && tx_done) begin
          done_next  = cur_onehot;
          gap_next   = '0;
          state_next = GAP;
        end else if (timer_reg >= DONE_LIMIT) begin
          err_next   = 1'b1;
          gap_next   = '0;
          state_next = GAP;
        end else begin
          timer_next = timer_inc;
        end
      end

      GAP: begin
        if (gap_reg >= GAP_LIMIT) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cur_reg   <= '0;
      timer_reg <= '0;
      gap_reg   <= '0;
      gnt_reg   <= '0;
      done_reg  <= '0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      send_reg  <= 1'b0;
      data_reg  <= 8'h00;
      par_reg   <= 2'b00;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cur_reg   <= cur_next;
      timer_reg <= timer_next;
      gap_reg   <= gap_next;
      gnt_reg   <= gnt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      busy_reg  <= busy_next;
      send_reg  <= send_next;
      data_reg  <= data_next;
      par_reg   <= par_next;
    end
  end

  assign gnt            = gnt_reg;
  assign done           = done_reg;
  assign err            = err_reg;
  assign busy           = busy_reg;
  assign tx_send        = send_reg;
  assign tx_data        = data_reg;
  assign tx_parity_type = par_reg;

endmodule
